// File: rtl/key_pad_matrix_model.sv
// COLS x ROWS keypad matrix emulator driving active-low row sense from active-low column drive.
// Define KEY_PAD_BOUNCE_EN for per-key contact bounce FSMs; otherwise contacts follow key_mask.
module key_pad_matrix_model #(
    parameter int unsigned COLS        = 4,
    parameter int unsigned ROWS        = 5,
    parameter int unsigned BOUNCE_CYC  = 12,
    parameter int unsigned BOUNCE_HALF = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS*ROWS-1:0] key_mask,
    input  logic [COLS-1:0]      key_column_in,
    output logic [ROWS-1:0]      key_row_out,
    output logic [COLS*ROWS-1:0] key_closed,
    output logic                 key_bouncing
);
    localparam int unsigned NumKeys = COLS * ROWS;

    if (BOUNCE_CYC < 2 || BOUNCE_HALF == 0) begin : g_bad_params
        $error("key_pad_matrix_model: BOUNCE_CYC must be >= 2 and BOUNCE_HALF >= 1");
    end

    logic [NumKeys-1:0] contact_q, contact_d;
    logic [ROWS-1:0]    row_q, row_d;
    logic               bouncing_q, bouncing_d;

`ifdef KEY_PAD_BOUNCE_EN
    localparam int unsigned CntW = $clog2(BOUNCE_CYC + 1);

    typedef enum logic [1:0] {StOpen, StBncPress, StClosed, StBncRel} key_state_e;

    key_state_e         state_q [NumKeys];
    key_state_e         state_d [NumKeys];
    logic [CntW-1:0]    cnt_q   [NumKeys];
    logic [CntW-1:0]    cnt_d   [NumKeys];
    logic [CntW-1:0]    cnt_inc [NumKeys];
    logic [NumKeys-1:0] settle, toggle, in_bnc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NumKeys; k++) begin
                state_q[k] <= StOpen;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NumKeys; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        settle = '0;
        toggle = '0;
        for (int unsigned k = 0; k < NumKeys; k++) begin
            cnt_inc[k] = cnt_q[k] + CntW'(1);
            settle[k]  = (cnt_inc[k] == CntW'(BOUNCE_CYC));
            toggle[k]  = ((32'(cnt_inc[k]) % BOUNCE_HALF) == 32'd0);
        end
    end

    // Next state: a mask reversal restarts the opposite bounce and beats counting.
    always_comb begin
        for (int unsigned k = 0; k < NumKeys; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                StOpen: begin
                    if (key_mask[k]) begin
                        state_d[k] = StBncPress;
                        cnt_d[k]   = '0;
                    end
                end
                StClosed: begin
                    if (!key_mask[k]) begin
                        state_d[k] = StBncRel;
                        cnt_d[k]   = '0;
                    end
                end
                StBncPress: begin
                    if (!key_mask[k]) begin
                        state_d[k] = StBncRel;
                        cnt_d[k]   = '0;
                    end else if (settle[k]) begin
                        state_d[k] = StClosed;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k]   = cnt_inc[k];
                    end
                end
                StBncRel: begin
                    if (key_mask[k]) begin
                        state_d[k] = StBncPress;
                        cnt_d[k]   = '0;
                    end else if (settle[k]) begin
                        state_d[k] = StOpen;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k]   = cnt_inc[k];
                    end
                end
                default: begin
                    state_d[k] = StOpen;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // Contact outputs; settling wins over a coincident toggle.
    always_comb begin
        in_bnc = '0;
        for (int unsigned k = 0; k < NumKeys; k++) begin
            contact_d[k] = contact_q[k];
            case (state_q[k])
                StOpen:   if (key_mask[k])  contact_d[k] = 1'b1;
                StClosed: if (!key_mask[k]) contact_d[k] = 1'b0;
                StBncPress: begin
                    if (!key_mask[k])   contact_d[k] = 1'b0;
                    else if (settle[k]) contact_d[k] = 1'b1;
                    else if (toggle[k]) contact_d[k] = ~contact_q[k];
                end
                StBncRel: begin
                    if (key_mask[k])    contact_d[k] = 1'b1;
                    else if (settle[k]) contact_d[k] = 1'b0;
                    else if (toggle[k]) contact_d[k] = ~contact_q[k];
                end
                default:  contact_d[k] = 1'b0;
            endcase
            in_bnc[k] = (state_d[k] == StBncPress) || (state_d[k] == StBncRel);
        end
        bouncing_d = |in_bnc;
    end
`else
    always_comb begin
        contact_d  = key_mask;
        bouncing_d = 1'b0;
    end
`endif

    // Row sense uses the contacts held before this edge.
    always_comb begin
        row_d = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (!key_column_in[c] && contact_q[c*ROWS + r]) begin
                    row_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            contact_q  <= '0;
            row_q      <= '1;
            bouncing_q <= 1'b0;
        end else begin
            contact_q  <= contact_d;
            row_q      <= row_d;
            bouncing_q <= bouncing_d;
        end
    end

    assign key_row_out  = row_q;
    assign key_closed   = contact_q;
    assign key_bouncing = bouncing_q;

endmodule

// File: tb/tb_key_pad_matrix_model.sv
// Self-checking bench for key_pad_matrix_model: steady-state vector table plus latency,
// bounce, reversal and asynchronous-reset sequences (bounce set only with KEY_PAD_BOUNCE_EN).
`timescale 1ns/1ps
module tb_key_pad_matrix_model;
    localparam int unsigned NumVecs = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] key_mask = '0;
    logic [3:0]  key_column_in = '1;
    logic [4:0]  key_row_out;
    logic [19:0] key_closed;
    logic        key_bouncing;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [19:0] mask;
        logic [3:0]  col;
        logic [4:0]  row;
    } vec_t;

    vec_t vecs [NumVecs];

    // Contact of key 7 at E0..E13 after a default press.
    bit exp_press [14] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    // Contact of key 0 at E0..E18: press at E0, released before E5.
    bit exp_rev [19] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

    key_pad_matrix_model dut (
        .clk          (clk),
        .rst          (rst),
        .key_mask     (key_mask),
        .key_column_in(key_column_in),
        .key_row_out  (key_row_out),
        .key_closed   (key_closed),
        .key_bouncing (key_bouncing)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{mask: 20'h00080, col: 4'b1101, row: 5'b11011};
        vecs[1] = '{mask: 20'h00011, col: 4'b1110, row: 5'b01110};
        vecs[2] = '{mask: 20'h00102, col: 4'b1100, row: 5'b10101};
        vecs[3] = '{mask: 20'h00102, col: 4'b1011, row: 5'b11111};
        vecs[4] = '{mask: 20'h80000, col: 4'b0111, row: 5'b01111};
        vecs[5] = '{mask: 20'hFFFFF, col: 4'b1111, row: 5'b11111};
        vecs[6] = '{mask: 20'hFFFFF, col: 4'b0000, row: 5'b00000};
        vecs[7] = '{mask: 20'h07C00, col: 4'b1011, row: 5'b00000};
        vecs[8] = '{mask: 20'h10400, col: 4'b0011, row: 5'b11100};
        vecs[9] = '{mask: 20'h00000, col: 4'b0000, row: 5'b11111};

        // Reset held with every key requested and every column driven.
        key_mask      = '1;
        key_column_in = '0;
        #5 rst = 1'b0;
        #1;
        check("rst_async_row", key_row_out, 5'b11111);
        check("rst_async_closed", key_closed, 20'h0);
        check("rst_async_bouncing", key_bouncing, 1'b0);
        tick(3);
        check("rst_held_row", key_row_out, 5'b11111);
        check("rst_held_closed", key_closed, 20'h0);
        check("rst_held_bouncing", key_bouncing, 1'b0);

        key_mask      = '0;
        key_column_in = '1;
        #10 rst = 1'b1;
        tick(2);

        for (int i = 0; i < NumVecs; i++) begin
            key_mask      = vecs[i].mask;
            key_column_in = vecs[i].col;
            tick(20);
            check($sformatf("vec%0d_row", i), key_row_out, vecs[i].row);
            check($sformatf("vec%0d_closed", i), key_closed, vecs[i].mask);
            check($sformatf("vec%0d_bouncing", i), key_bouncing, 1'b0);
        end

`ifndef KEY_PAD_BOUNCE_EN
        // Direct contact path: mask -> contact in one edge, row one edge later.
        key_mask      = 20'h80000;
        key_column_in = 4'b0111;
        tick(1);
        check("direct_e0_closed", key_closed, 20'h80000);
        check("direct_e0_row", key_row_out, 5'b11111);
        check("direct_e0_bouncing", key_bouncing, 1'b0);
        tick(1);
        check("direct_e1_row", key_row_out, 5'b01111);
        key_column_in = 4'b1111;
        tick(1);
        check("col_release_row", key_row_out, 5'b11111);
        key_column_in = 4'b0111;
        tick(1);
        check("col_redrive_row", key_row_out, 5'b01111);

        // Reset mid-press, between edges.
        #20 rst = 1'b0;
        #1;
        check("midrst_row", key_row_out, 5'b11111);
        check("midrst_closed", key_closed, 20'h0);
        check("midrst_bouncing", key_bouncing, 1'b0);
        #10 rst = 1'b1;
        tick(1);
        check("postrst_e0_closed", key_closed, 20'h80000);
        check("postrst_e0_row", key_row_out, 5'b11111);
        tick(1);
        check("postrst_e1_row", key_row_out, 5'b01111);
`else
        // Single key press with default bounce parameters.
        key_column_in = 4'b1101;
        key_mask      = 20'h00080;
        for (int n = 0; n < 14; n++) begin
            logic [4:0] exp_row;
            exp_row = 5'b11111;
            if (n > 0 && exp_press[n-1]) exp_row = 5'b11011;
            tick(1);
            check($sformatf("press_e%0d_closed", n), key_closed[7], exp_press[n]);
            check($sformatf("press_e%0d_row", n), key_row_out, exp_row);
            check($sformatf("press_e%0d_bouncing", n), key_bouncing, (n < 12) ? 1'b1 : 1'b0);
        end
        key_mask = '0;
        tick(20);

        // Reversal mid-press.
        key_column_in = 4'b1110;
        key_mask      = 20'h00001;
        for (int n = 0; n < 19; n++) begin
            if (n == 5) key_mask = '0;
            tick(1);
            check($sformatf("rev_e%0d_closed", n), key_closed[0], exp_rev[n]);
            check($sformatf("rev_e%0d_bouncing", n), key_bouncing, (n < 17) ? 1'b1 : 1'b0);
        end
        tick(4);

        // Reset mid-bounce aborts; held mask restarts the press bounce.
        key_mask = 20'h00001;
        tick(4);
        #20 rst = 1'b0;
        #1;
        check("midrst_row", key_row_out, 5'b11111);
        check("midrst_closed", key_closed, 20'h0);
        check("midrst_bouncing", key_bouncing, 1'b0);
        #10 rst = 1'b1;
        tick(1);
        check("postrst_e0_closed", key_closed, 20'h00001);
        check("postrst_e0_bouncing", key_bouncing, 1'b1);
        tick(2);
        check("postrst_e2_closed", key_closed, 20'h00000);
        check("postrst_e2_row", key_row_out, 5'b11110);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
